id_ex_stage: RTL and testbench

Execute-entry pipeline register for the RV32I core. Captures decoded instruction fields from the ID stage each cycle, derives the 4-bit ALU control code, resolves A/B operands with EX/MEM and MEM/WB forwarding, and detects load-use hazards. It drives the ALU directly: ex_alu_a/ex_alu_b feed A/B, and ex_alu_control feeds ALUControl.

---
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU decode, operand forwarding and hazard detection
// Optional feature macro: FORWARDING_EN (EX/MEM and MEM/WB operand forwarding).
// Without it, operands come straight from the registered values and the
// hazard output widens to cover every in-flight RAW dependency.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [1:0]      id_alu_op,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            stall,
  input  logic            flush,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            exmem_reg_write,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [3:0]      ex_alu_control,
  output logic [1:0]      ex_slt_kind,
  output logic [XLEN-1:0] ex_store_data,
  output logic [REGW-1:0] ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            load_use_hazard
);

  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [REGW-1:0] rs1_q;
  logic [REGW-1:0] rs2_q;
  logic            alu_src_q;
  logic [3:0]      alu_control_d;
  logic [1:0]      slt_kind_d;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // ALU code derived from the ID fields so EX sees a registered control code
  always_comb begin
    alu_control_d = 4'b0010;
    slt_kind_d    = 2'b00;
    case (id_alu_op)
      2'b00: alu_control_d = 4'b0010;
      2'b01: alu_control_d = 4'b0110;
      default: begin
        case (id_funct3)
          3'b000: alu_control_d = (id_alu_op == 2'b10 && id_funct7b5) ? 4'b0110 : 4'b0010;
          3'b111: alu_control_d = 4'b0000;
          3'b110: alu_control_d = 4'b0001;
          3'b100: alu_control_d = 4'b0011;
          3'b001: alu_control_d = 4'b0100;
          // shift-right type comes from bit 30 for both R and I forms
          3'b101: alu_control_d = id_funct7b5 ? 4'b0111 : 4'b0101;
          3'b010: begin
            alu_control_d = 4'b0110;
            slt_kind_d    = 2'b01;
          end
          default: begin
            alu_control_d = 4'b0110;
            slt_kind_d    = 2'b10;
          end
        endcase
      end
    endcase
  end

  // Valid and control bits: reset/flush clear, stall holds, hazard inserts a bubble
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
    end else if (!stall) begin
      if (load_use_hazard) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_branch    <= 1'b0;
      end else begin
        ex_valid     <= id_valid;
        ex_reg_write <= id_reg_write & id_valid;
        ex_mem_read  <= id_mem_read  & id_valid;
        ex_mem_write <= id_mem_write & id_valid;
        ex_branch    <= id_branch    & id_valid;
      end
    end
  end

  // Data fields: reset clears, stall holds, otherwise capture every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pc          <= '0;
      rs1_data_q     <= '0;
      rs2_data_q     <= '0;
      imm_q          <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      ex_rd          <= '0;
      alu_src_q      <= 1'b0;
      ex_funct3      <= 3'b000;
      ex_alu_control <= 4'b0010;
      ex_slt_kind    <= 2'b00;
    end else if (!stall) begin
      ex_pc          <= id_pc;
      rs1_data_q     <= id_rs1_data;
      rs2_data_q     <= id_rs2_data;
      imm_q          <= id_imm;
      rs1_q          <= id_rs1;
      rs2_q          <= id_rs2;
      ex_rd          <= id_rd;
      alu_src_q      <= id_alu_src;
      ex_funct3      <= id_funct3;
      ex_alu_control <= alu_control_d;
      ex_slt_kind    <= slt_kind_d;
    end
  end

`ifdef FORWARDING_EN
  // Youngest producer wins; x0 never forwards
  function automatic logic [XLEN-1:0] fwd(input logic [REGW-1:0] idx, input logic [XLEN-1:0] data);
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == idx)
      return exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == idx)
      return memwb_result;
    else
      return data;
  endfunction

  // Operand muxes and load-use check, same cycle
  always_comb begin
    rs1_fwd = fwd(rs1_q, rs1_data_q);
    rs2_fwd = fwd(rs2_q, rs2_data_q);
    load_use_hazard = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end
`else
  logic fwd_unused;

  function automatic logic raw(input logic [REGW-1:0] rd, input logic we);
    return we && rd != '0 && (rd == id_rs1 || rd == id_rs2);
  endfunction

  // No bypass: hold ID until every older writer of a source has retired
  always_comb begin
    rs1_fwd    = rs1_data_q;
    rs2_fwd    = rs2_data_q;
    fwd_unused = ^{rs1_q, rs2_q, exmem_result, memwb_result};
    load_use_hazard = id_valid & (raw(ex_rd, ex_reg_write & ex_valid) |
                                  raw(exmem_rd, exmem_reg_write) |
                                  raw(memwb_rd, memwb_reg_write));
  end
`endif

  assign ex_alu_a      = rs1_fwd;
  assign ex_alu_b      = alu_src_q ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, id_valid, id_funct7b5, id_alu_src;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, stall, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, load_use_hazard;
  logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
  logic [3:0]  ex_alu_control;
  logic [1:0]  ex_slt_kind;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;
  chk_t sb[$];
  int   errors = 0;
  int   checks = 0;

  localparam int S_VALID = 0, S_PC = 1, S_A = 2, S_B = 3, S_CTRL = 4, S_SLT = 5, S_STORE = 6,
                 S_RD = 7, S_F3 = 8, S_RW = 9, S_MR = 10, S_MW = 11, S_BR = 12, S_HAZ = 13;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .stall(stall), .flush(flush),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_reg_write(exmem_reg_write),
    .memwb_reg_write(memwb_reg_write), .exmem_result(exmem_result), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_alu_control(ex_alu_control), .ex_slt_kind(ex_slt_kind), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_VALID: return {31'b0, ex_valid};
      S_PC:    return ex_pc;
      S_A:     return ex_alu_a;
      S_B:     return ex_alu_b;
      S_CTRL:  return {28'b0, ex_alu_control};
      S_SLT:   return {30'b0, ex_slt_kind};
      S_STORE: return ex_store_data;
      S_RD:    return {27'b0, ex_rd};
      S_F3:    return {29'b0, ex_funct3};
      S_RW:    return {31'b0, ex_reg_write};
      S_MR:    return {31'b0, ex_mem_read};
      S_MW:    return {31'b0, ex_mem_write};
      S_BR:    return {31'b0, ex_branch};
      default: return {31'b0, load_use_hazard};
    endcase
  endfunction

  // Expected operand value given the forwarding inputs currently driven
  function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] d);
`ifdef FORWARDING_EN
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idx) return memwb_result;
`endif
    return d;
  endfunction

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [1:0] op, input logic [2:0] f3,
                        input logic f7, input logic src, input logic rw, input logic mr,
                        input logic mw, input logic br);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_op = op;
    id_funct3 = f3; id_funct7b5 = f7; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_branch = br;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_fwd(input logic [4:0] er, input logic [31:0] eres, input logic ew,
                         input logic [4:0] mr, input logic [31:0] mres, input logic mw);
    exmem_rd = er; exmem_result = eres; exmem_reg_write = ew;
    memwb_rd = mr; memwb_result = mres; memwb_reg_write = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are live every cycle, so drain all expectations on each falling edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = sb.pop_front();
      act = sample(c.sel);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [1:0] t_op  [12] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11};
  logic [2:0] t_f3  [12] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b101, 3'b010, 3'b011};
  logic       t_f7  [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] t_ctl [12] = '{4'h2, 4'h6, 4'h2, 4'h2, 4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h7, 4'h6, 4'h6};
  logic [1:0] t_slt [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    set_fwd(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    tick();
    push("rst_valid", S_VALID, 0); push("rst_rw", S_RW, 0); push("rst_mr", S_MR, 0);
    push("rst_mw", S_MW, 0); push("rst_br", S_BR, 0); push("rst_ctrl", S_CTRL, 32'h2);
    push("rst_a", S_A, 0); push("rst_b", S_B, 0); push("rst_pc", S_PC, 0);
    push("rst_rd", S_RD, 0); push("rst_slt", S_SLT, 0); push("rst_haz", S_HAZ, 0);
    rst = 1'b0;

    // R-type SUB
    set_id(1, 32'h100, 1, 2, 3, 10, 3, 0, 2'b10, 3'b000, 1, 0, 1, 0, 0, 0);
    tick();
    push("sub_valid", S_VALID, 1); push("sub_ctrl", S_CTRL, 32'h6); push("sub_a", S_A, 10);
    push("sub_b", S_B, 3); push("sub_pc", S_PC, 32'h100); push("sub_rd", S_RD, 3);
    push("sub_rw", S_RW, 1); push("sub_store", S_STORE, 3);

    // SRAI with immediate operand
    set_id(1, 32'h104, 1, 0, 4, 10, 0, 4, 2'b11, 3'b101, 1, 1, 1, 0, 0, 0);
    tick();
    push("srai_ctrl", S_CTRL, 32'h7); push("srai_b", S_B, 4); push("srai_a", S_A, 10);
    push("srai_store", S_STORE, 0); push("srai_rd", S_RD, 4);

    // ALU decode table
    for (int i = 0; i < 12; i++) begin
      set_id(1, 32'h200 + 4 * i, 1, 2, 3, 7, 9, 32'h20, t_op[i], t_f3[i], t_f7[i], 0, 1, 0, 0, 0);
      tick();
      push($sformatf("dec%0d_ctrl", i), S_CTRL, {28'b0, t_ctl[i]});
      push($sformatf("dec%0d_slt", i), S_SLT, {30'b0, t_slt[i]});
      push($sformatf("dec%0d_f3", i), S_F3, {29'b0, t_f3[i]});
    end

    // Forwarding priority, held in EX by stall while sources change
    set_id(1, 32'h300, 5, 6, 7, 32'h55, 32'h66, 32'h40, 2'b10, 3'b000, 0, 0, 1, 0, 0, 0);
    tick();
    idle(); stall = 1'b1;
    set_fwd(5, 32'h11, 1, 5, 32'h22, 1);
    push("fwd_both_a", S_A, model_fwd(5, 32'h55)); push("fwd_both_b", S_B, model_fwd(6, 32'h66));
    tick();
    set_fwd(5, 32'h11, 0, 6, 32'h22, 1);
    push("fwd_wb_a", S_A, model_fwd(5, 32'h55)); push("fwd_wb_b", S_B, model_fwd(6, 32'h66));
    push("fwd_wb_store", S_STORE, model_fwd(6, 32'h66));
    tick();
    set_fwd(6, 32'h33, 1, 6, 32'h22, 1);
    push("fwd_prio_b", S_B, model_fwd(6, 32'h66));
    stall = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);

    // x0 source never forwards; alu_src picks imm while store data still forwards
    set_id(1, 32'h304, 0, 6, 8, 32'h99, 32'h66, 32'h44, 2'b11, 3'b000, 0, 1, 1, 0, 0, 0);
    tick();
    idle(); stall = 1'b1;
    set_fwd(0, 32'h11, 1, 6, 32'h22, 1);
    push("x0_a", S_A, model_fwd(0, 32'h99)); push("imm_b", S_B, 32'h44);
    push("imm_store", S_STORE, model_fwd(6, 32'h66));
    tick();
    stall = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);

    // Stall holds everything while ID changes
    set_id(1, 32'h400, 1, 2, 9, 32'hA, 32'hB, 32'hC, 2'b10, 3'b100, 0, 0, 1, 0, 0, 0);
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_id(1, 32'h500 + 4 * k, 3, 4, 10 + k, k, k, k, 2'b11, 3'b001, 0, 1, 0, 1, 1, 1);
      tick();
      push($sformatf("stall%0d_pc", k), S_PC, 32'h400); push($sformatf("stall%0d_a", k), S_A, 32'hA);
      push($sformatf("stall%0d_b", k), S_B, 32'hB); push($sformatf("stall%0d_ctrl", k), S_CTRL, 32'h3);
      push($sformatf("stall%0d_rd", k), S_RD, 9); push($sformatf("stall%0d_valid", k), S_VALID, 1);
      push($sformatf("stall%0d_rw", k), S_RW, 1); push($sformatf("stall%0d_mw", k), S_MW, 0);
    end

    // Flush outranks stall
    flush = 1'b1;
    tick();
    push("flush_valid", S_VALID, 0); push("flush_rw", S_RW, 0); push("flush_mr", S_MR, 0);
    push("flush_mw", S_MW, 0); push("flush_br", S_BR, 0);
    flush = 1'b0; stall = 1'b0;

    // Load-use: lw x6 then add x11, x6, x7
    set_id(1, 32'h600, 2, 0, 6, 32'h1000, 0, 8, 2'b00, 3'b010, 0, 1, 1, 1, 0, 0);
    tick();
    push("lw_valid", S_VALID, 1); push("lw_mr", S_MR, 1); push("lw_a", S_A, 32'h1000);
    push("lw_b", S_B, 8); push("lw_ctrl", S_CTRL, 32'h2);
    set_id(1, 32'h604, 6, 7, 11, 32'h5, 32'h6, 0, 2'b10, 3'b000, 0, 0, 1, 0, 0, 0);
    push("lu_haz", S_HAZ, 1);
    tick();
    set_fwd(6, 32'h77, 1, 0, 0, 0);
    push("bubble_valid", S_VALID, 0); push("bubble_mr", S_MR, 0); push("bubble_rw", S_RW, 0);
`ifdef FORWARDING_EN
    push("bubble_haz", S_HAZ, 0);
    tick();
    set_fwd(0, 0, 0, 6, 32'h77, 1);
    push("add_valid", S_VALID, 1); push("add_pc", S_PC, 32'h604);
    push("add_a", S_A, 32'h77); push("add_b", S_B, 32'h6); push("add_rd", S_RD, 11);
`else
    push("bubble_haz", S_HAZ, 1);
    tick();
    set_fwd(0, 0, 0, 6, 32'h77, 1);
    push("bubble2_valid", S_VALID, 0); push("bubble2_haz", S_HAZ, 1);
    tick();
    set_fwd(0, 0, 0, 0, 0, 0);
    push("bubble3_valid", S_VALID, 0); push("bubble3_haz", S_HAZ, 0);
    tick();
    push("add_valid", S_VALID, 1); push("add_pc", S_PC, 32'h604);
    push("add_a", S_A, 32'h5); push("add_b", S_B, 32'h6); push("add_rd", S_RD, 11);
`endif

    // Reset during stall clears the stage
    idle(); stall = 1'b1; rst = 1'b1;
    tick();
    push("rst_stall_valid", S_VALID, 0); push("rst_stall_pc", S_PC, 0);
    push("rst_stall_ctrl", S_CTRL, 32'h2); push("rst_stall_a", S_A, 0); push("rst_stall_rw", S_RW, 0);
    @(negedge clk);
    #1;
    rst = 1'b0; stall = 1'b0;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
